// File: rtl/alu_exec_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_stage
// Description : EX-stage execution unit. Takes operands, a 4-bit ALUOp and a
//               destination tag over a valid/ready handshake, computes the
//               result together with branch, overflow and illegal-op flags,
//               and presents everything to MEM one cycle later. Supports
//               backpressure (stall) and flush (branch mispredict).
// Ports       : clk, reset (async, active-high), flush
//               in_valid / in_ready / in_alu_op / in_a / in_b / in_tag
//               out_valid / out_ready / out_result / out_tag
//               out_branch / out_ovf / out_illegal
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_stage #(
   parameter int DATA_WIDTH = 16,
   parameter int TAG_WIDTH  = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            in_alu_op,
   input  logic [DATA_WIDTH-1:0] in_a,
   input  logic [DATA_WIDTH-1:0] in_b,
   input  logic [TAG_WIDTH-1:0]  in_tag,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_result,
   output logic [TAG_WIDTH-1:0]  out_tag,
   output logic                  out_branch,
   output logic                  out_ovf,
   output logic                  out_illegal
);

   localparam logic [3:0] c_OP_ADD   = 4'b0000;
   localparam logic [3:0] c_OP_SUB   = 4'b0001;
   localparam logic [3:0] c_OP_PASSA = 4'b0010;
   localparam logic [3:0] c_OP_NOT   = 4'b0011;
   localparam logic [3:0] c_OP_AND   = 4'b0100;
   localparam logic [3:0] c_OP_OR    = 4'b0101;
   localparam logic [3:0] c_OP_BNE   = 4'b0110;
   localparam logic [3:0] c_OP_BEQ   = 4'b0111;
   localparam logic [3:0] c_OP_BGZ   = 4'b1000;
   localparam logic [3:0] c_OP_BLZ   = 4'b1001;
   localparam logic [3:0] c_OP_PASSB = 4'b1010;
   localparam logic [3:0] c_OP_SHL   = 4'b1100;
   localparam logic [3:0] c_OP_SHR   = 4'b1101;
   localparam logic [3:0] c_OP_TCP   = 4'b1110;

   localparam int c_MSB = DATA_WIDTH - 1;

   logic                  r_valid;
   logic [DATA_WIDTH-1:0] r_result;
   logic [TAG_WIDTH-1:0]  r_tag;
   logic                  r_branch;
   logic                  r_ovf;
   logic                  r_illegal;

   logic                  w_inReady;
   logic                  w_accept;
   logic [DATA_WIDTH-1:0] w_sum;
   logic [DATA_WIDTH-1:0] w_diff;
   logic [DATA_WIDTH-1:0] w_nextResult;
   logic                  w_nextBranch;
   logic                  w_nextOvf;
   logic                  w_nextIllegal;

   // Space is available when the output slot is empty or being drained
   // this cycle; this is what allows back-to-back ops with no bubble.
   assign w_inReady = !r_valid | out_ready;
   assign w_accept  = in_valid & w_inReady & !flush;

   assign w_sum  = in_a + in_b;
   assign w_diff = in_a - in_b;

   always_comb begin
      w_nextResult  = '0;
      w_nextBranch  = 1'b0;
      w_nextOvf     = 1'b0;
      w_nextIllegal = 1'b0;
      case (in_alu_op)
         c_OP_ADD: begin
            w_nextResult = w_sum;
            w_nextOvf    = (in_a[c_MSB] == in_b[c_MSB]) & (w_sum[c_MSB] != in_a[c_MSB]);
         end
         c_OP_SUB: begin
            w_nextResult = w_diff;
            w_nextOvf    = (in_a[c_MSB] != in_b[c_MSB]) & (w_diff[c_MSB] != in_a[c_MSB]);
         end
         c_OP_PASSA: w_nextResult = in_a;
         c_OP_NOT:   w_nextResult = ~in_a;
         c_OP_AND:   w_nextResult = in_a & in_b;
         c_OP_OR:    w_nextResult = in_a | in_b;
         c_OP_PASSB: w_nextResult = in_b;
         c_OP_SHL:   w_nextResult = {in_a[c_MSB-1:0], 1'b0};
         c_OP_SHR:   w_nextResult = {in_a[c_MSB], in_a[c_MSB:1]};
         c_OP_TCP:   w_nextResult = '0 - in_a;
         // Compare ops leave the result at zero and only drive the branch flag.
         c_OP_BNE:   w_nextBranch = (in_a != in_b);
         c_OP_BEQ:   w_nextBranch = (in_a == in_b);
         c_OP_BGZ:   w_nextBranch = !in_a[c_MSB] & (|in_a);
         c_OP_BLZ:   w_nextBranch = in_a[c_MSB];
         default:    w_nextIllegal = 1'b1;   // 1011 and 1111
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid   <= 1'b0;
         r_result  <= '0;
         r_tag     <= '0;
         r_branch  <= 1'b0;
         r_ovf     <= 1'b0;
         r_illegal <= 1'b0;
      end else if (flush) begin
         // Kills both the held op and any incoming op.
         r_valid <= 1'b0;
      end else if (w_accept) begin
         r_valid   <= 1'b1;
         r_result  <= w_nextResult;
         r_tag     <= in_tag;
         r_branch  <= w_nextBranch;
         r_ovf     <= w_nextOvf;
         r_illegal <= w_nextIllegal;
      end else if (out_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign in_ready    = w_inReady;
   assign out_valid   = r_valid;
   assign out_result  = r_result;
   assign out_tag     = r_tag;
   assign out_branch  = r_branch;
   assign out_ovf     = r_ovf;
   assign out_illegal = r_illegal;

endmodule
`default_nettype wire
